priv_trap_controller: RTL and testbench
=======================================

PRIV_TRAP_CONTROLLER -- requirements
Module: priv_trap_controller

Interface
- REQ-001 SHALL have parameter NUM_INT, default 16: number of interrupt sources, 1..31.
- REQ-002 SHALL have parameter NUM_EXC, default 16: number of exception sources, 1..32.
- REQ-003 SHALL have parameter XLEN, default 32: width of PC, tval, mtvec and cause.
- REQ-004 CLK  in  1  sole clock; all state on rising edge.
- REQ-005 RST  in  1  reset; synchronous, active-high.
- REQ-006 int_src  in  NUM_INT  level interrupt requests; bit i is cause code i.
- REQ-007 int_clear  in  NUM_INT  per-source pending clear.
- REQ-008 int_mask  in  NUM_INT  per-source enable (mie equivalent).
- REQ-009 exc_src  in  NUM_EXC  exception requests; bit i is cause code i.
- REQ-010 epc, tval  in  XLEN  faulting PC and trap value, sampled at exception capture.
- REQ-011 mtvec  in  XLEN  trap vector; [1:0] is mode (1 = vectored), [XLEN-1:2] is base.
- REQ-012 pipe_clear  in  1  pipeline is drained of hazards.
- REQ-013 mret  in  1  return-from-trap request.
- REQ-014 insert_pc  out  1  one-cycle redirect strobe.
- REQ-015 priv_pc  out  XLEN  redirect target; valid only while insert_pc=1.
- REQ-016 pending  out  NUM_INT  registered pending vector (mip equivalent).
- REQ-017 mcause  out  XLEN  [XLEN-1] is the interrupt flag, low bits are the cause code.
- REQ-018 mepc, mtval  out  XLEN  registered trap PC and trap value.
- REQ-019 mstatus_mie, mstatus_mpie  out  1  global interrupt enable and its previous value.
- REQ-020 busy  out  1  FSM is not in IDLE.

Function
- REQ-021 Pending update SHALL be: pending_next = (pending & ~int_clear) | int_src. An asserted source wins over a same-cycle clear.
- REQ-022 Interrupt candidate SHALL be eligible only when (pending & int_mask) is nonzero and mstatus_mie=1. Among eligible bits, the highest index wins.
- REQ-023 Exception priority SHALL be lowest index first. Any exception SHALL outrank any interrupt.
- REQ-024 FSM states SHALL be IDLE, WAIT, TRAP and RET, with 2-bit encoding.
- REQ-025 In IDLE, when any exc_src bit is set, the block SHALL latch mcause={0,code}, mepc=epc and mtval=tval, then go to WAIT.
- REQ-026 Otherwise in IDLE, when an interrupt candidate exists, the block SHALL latch mcause={1,code}, mepc=epc and mtval=0, then go to WAIT.
- REQ-027 Otherwise in IDLE, when mret=1 and pipe_clear=1, the FSM SHALL go to RET.
- REQ-028 If a trap and mret are requested in the same IDLE cycle, the trap SHALL win and mret SHALL be dropped.
- REQ-029 In WAIT, an exception SHALL re-latch mcause, mepc and mtval (it overrides a waiting interrupt or an older exception). New interrupts SHALL be ignored.
- REQ-030 In WAIT with a latched interrupt, if (pending & int_mask)[code]=0 or mstatus_mie=0, the FSM SHALL return to IDLE with no redirect.
- REQ-031 In WAIT, pipe_clear=1 SHALL move the FSM to TRAP on the next edge.
- REQ-032 TRAP SHALL last one cycle, with insert_pc=1 and then return to IDLE. On exit: mstatus_mpie<=mstatus_mie, mstatus_mie<=0.
- REQ-033 In TRAP, priv_pc SHALL be {base,2'b00} + 4*code when mode=1 and mcause is an interrupt, and {base,2'b00} otherwise. Arithmetic is modulo 2^XLEN.
- REQ-034 RET SHALL last one cycle, with insert_pc=1 and priv_pc=mepc, then return to IDLE. On exit: mstatus_mie<=mstatus_mpie, mstatus_mpie<=1.
- REQ-035 Minimum trap latency SHALL be 2 cycles from request to insert_pc.
- REQ-036 insert_pc SHALL be 0 in IDLE and WAIT.
- REQ-037 mcause, mepc and mtval SHALL change only on capture in IDLE or WAIT.
- REQ-038 pending SHALL update every cycle in all states.

Reset
- REQ-039 RST=1 at an edge SHALL force IDLE and drive all outputs to 0, including pending, mcause, mepc, mtval, mstatus_mie and mstatus_mpie.
- REQ-040 RST SHALL abort an in-flight WAIT, TRAP or RET with no redirect.
- REQ-041 RST SHALL take priority over every other input in the same cycle.

Verification
- REQ-042 Exception with exc_src=0x0004 and 0x0100 together, epc=0x80, pipe_clear=1: the TRAP cycle shows mcause=2, mepc=0x80 and priv_pc=mtvec base. After the trap, mstatus_mie=0 and mstatus_mpie equals the prior mstatus_mie.
- REQ-043 Vectored interrupt with mtvec=0x1001, mstatus_mie=1, int_src bits 3 and 11, masks set: mcause=0x8000000B and priv_pc=0x102C.
- REQ-044 Override in WAIT: an interrupt is waiting with pipe_clear=0, then exc_src bit 5 arrives. The TRAP cycle shows mcause=5 and the exception's epc.
- REQ-045 Abandon: an interrupt is waiting, then int_clear is pulsed while the source is low. The FSM returns to IDLE with no insert_pc.
- REQ-046 mret with mepc=0x200 and mpie=1: RET shows priv_pc=0x200, then mstatus_mie=1 and mstatus_mpie=1.
- REQ-047 RST asserted in WAIT: the next cycle shows busy=0 and all outputs 0. A simultaneous int_src and int_clear on the same bit keeps that bit pending.

Source files
------------

// File: rtl/priv_trap_controller_if.sv
// Trap-controller bus: trap/interrupt requests in, redirect and CSR state out.
// The master drives the requests and the slave (the controller) drives the redirect and CSR outputs.
interface priv_trap_controller_if #(
    parameter int NUM_INT = 16,
    parameter int NUM_EXC = 16,
    parameter int XLEN    = 32
);
    logic [NUM_INT-1:0] int_src;
    logic [NUM_INT-1:0] int_clear;
    logic [NUM_INT-1:0] int_mask;
    logic [NUM_EXC-1:0] exc_src;
    logic [XLEN-1:0]    epc;
    logic [XLEN-1:0]    tval;
    logic [XLEN-1:0]    mtvec;
    logic               pipe_clear;
    logic               mret;

    logic               insert_pc;
    logic [XLEN-1:0]    priv_pc;
    logic [NUM_INT-1:0] pending;
    logic [XLEN-1:0]    mcause;
    logic [XLEN-1:0]    mepc;
    logic [XLEN-1:0]    mtval;
    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic               busy;

    modport master (
        output int_src, int_clear, int_mask, exc_src, epc, tval, mtvec, pipe_clear, mret,
        input  insert_pc, priv_pc, pending, mcause, mepc, mtval, mstatus_mie, mstatus_mpie, busy
    );

    modport slave (
        input  int_src, int_clear, int_mask, exc_src, epc, tval, mtvec, pipe_clear, mret,
        output insert_pc, priv_pc, pending, mcause, mepc, mtval, mstatus_mie, mstatus_mpie, busy
    );
endinterface

// File: rtl/priv_trap_controller.sv
// Machine-mode trap controller: captures exceptions/interrupts, then redirects the PC once the pipe drains.
// Redirect appears >=2 cycles after a request; the block waits in WAIT for pipe_clear as its only backpressure.
module priv_trap_controller #(
    parameter int NUM_INT = 16,
    parameter int NUM_EXC = 16,
    parameter int XLEN    = 32
) (
    input logic                 clk,
    input logic                 rst,
    priv_trap_controller_if.slave bus
);
    localparam int CW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;
    localparam logic [1:0] S_RET  = 2'd3;

    logic [1:0]         state;
    logic [NUM_INT-1:0] pending_q;
    logic [XLEN-1:0]    mcause_q;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mtval_q;
    logic               mie_q;
    logic               mpie_q;

    logic               exc_hit;
    logic [CW-1:0]      exc_code;
    logic [NUM_INT-1:0] int_elig;
    logic               int_hit;
    logic [CW-1:0]      int_code;
    logic               lat_en;
    logic [XLEN-1:0]    trap_base;
    logic [XLEN-1:0]    trap_target;

    function automatic logic [XLEN-1:0] cause_word(input logic intr, input logic [CW-1:0] code);
        logic [XLEN-1:0] w;
        w           = '0;
        w[CW-1:0]   = code;
        w[XLEN-1]   = intr;
        return w;
    endfunction

    // Exceptions: lowest index wins. Interrupts: highest eligible index wins.
    always_comb begin
        exc_hit  = |bus.exc_src;
        exc_code = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (bus.exc_src[i]) exc_code = CW'(i);
        end
        int_elig = pending_q & bus.int_mask;
        int_hit  = mie_q && (|int_elig);
        int_code = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (int_elig[i]) int_code = CW'(i);
        end
    end

    // A latched interrupt stays valid only while its own source is still pending and enabled.
    assign lat_en = |(int_elig & (NUM_INT'(1) << mcause_q[CW-1:0]));

    assign trap_base   = {bus.mtvec[XLEN-1:2], 2'b00};
    assign trap_target = (bus.mtvec[1:0] == 2'b01 && mcause_q[XLEN-1])
                       ? trap_base + {mcause_q[XLEN-3:0], 2'b00}
                       : trap_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pending_q <= '0;
            mcause_q  <= '0;
            mepc_q    <= '0;
            mtval_q   <= '0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
        end else begin
            pending_q <= (pending_q & ~bus.int_clear) | bus.int_src;
            case (state)
                S_IDLE: begin
                    if (exc_hit) begin
                        mcause_q <= cause_word(1'b0, exc_code);
                        mepc_q   <= bus.epc;
                        mtval_q  <= bus.tval;
                        state    <= S_WAIT;
                    end else if (int_hit) begin
                        mcause_q <= cause_word(1'b1, int_code);
                        mepc_q   <= bus.epc;
                        mtval_q  <= '0;
                        state    <= S_WAIT;
                    end else if (bus.mret && bus.pipe_clear) begin
                        state    <= S_RET;
                    end
                end
                S_WAIT: begin
                    if (exc_hit) begin
                        mcause_q <= cause_word(1'b0, exc_code);
                        mepc_q   <= bus.epc;
                        mtval_q  <= bus.tval;
                        if (bus.pipe_clear) state <= S_TRAP;
                    end else if (mcause_q[XLEN-1] && (!mie_q || !lat_en)) begin
                        state <= S_IDLE;
                    end else if (bus.pipe_clear) begin
                        state <= S_TRAP;
                    end
                end
                S_TRAP: begin
                    mpie_q <= mie_q;
                    mie_q  <= 1'b0;
                    state  <= S_IDLE;
                end
                S_RET: begin
                    mie_q  <= mpie_q;
                    mpie_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.insert_pc    = (state == S_TRAP) || (state == S_RET);
    assign bus.priv_pc      = (state == S_TRAP) ? trap_target :
                              (state == S_RET)  ? mepc_q      : '0;
    assign bus.pending      = pending_q;
    assign bus.mcause       = mcause_q;
    assign bus.mepc         = mepc_q;
    assign bus.mtval        = mtval_q;
    assign bus.mstatus_mie  = mie_q;
    assign bus.mstatus_mpie = mpie_q;
    assign bus.busy         = (state != S_IDLE);
endmodule

// File: tb/tb_priv_trap_controller.sv
// Directed bench for priv_trap_controller: expected redirects are queued by the stimulus
// and popped by a separate monitor whenever insert_pc is seen.
module tb_priv_trap_controller;
    localparam int NUM_INT = 16;
    localparam int NUM_EXC = 16;
    localparam int XLEN    = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priv_trap_controller_if #(.NUM_INT(NUM_INT), .NUM_EXC(NUM_EXC), .XLEN(XLEN)) bus ();

    priv_trap_controller #(.NUM_INT(NUM_INT), .NUM_EXC(NUM_EXC), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] epc;
        string       tag;
    } redir_t;

    redir_t exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_redirect(input logic [31:0] pc, input logic [31:0] cause,
                                   input logic [31:0] epc, input string tag);
        redir_t r;
        r.pc = pc; r.cause = cause; r.epc = epc; r.tag = tag;
        exp_q.push_back(r);
    endtask

    task automatic do_mret();
        bus.mret = 1'b1; bus.pipe_clear = 1'b1;
        tick();
        bus.mret = 1'b0; bus.pipe_clear = 1'b0;
        tick();
    endtask

    task automatic clear_pending();
        bus.int_clear = '1;
        tick();
        bus.int_clear = '0;
    endtask

    // Monitor: every redirect must match the oldest queued expectation.
    initial begin
        redir_t e;
        forever begin
            @(negedge clk);
            if (bus.insert_pc === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_redirect: got priv_pc 0x%0h required no insert_pc", bus.priv_pc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.tag, "_priv_pc"}, bus.priv_pc, e.pc);
                    check({e.tag, "_mcause"},  bus.mcause,  e.cause);
                    check({e.tag, "_mepc"},    bus.mepc,    e.epc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset must dominate a full set of active requests.
        rst = 1'b1;
        bus.int_src = '1; bus.int_clear = '0; bus.int_mask = '1;
        bus.exc_src = 16'h0001; bus.epc = 32'h1234; bus.tval = 32'h99;
        bus.mtvec = 32'h1001; bus.pipe_clear = 1'b1; bus.mret = 1'b1;
        tick(2);
        check("rst_busy",      32'(bus.busy),         0);
        check("rst_insert_pc", 32'(bus.insert_pc),    0);
        check("rst_pending",   32'(bus.pending),      0);
        check("rst_mcause",    bus.mcause,            0);
        check("rst_mepc",      bus.mepc,              0);
        check("rst_mtval",     bus.mtval,             0);
        check("rst_mie",       32'(bus.mstatus_mie),  0);
        check("rst_mpie",      32'(bus.mstatus_mpie), 0);
        bus.int_src = '0; bus.exc_src = '0; bus.pipe_clear = 1'b0; bus.mret = 1'b0;
        rst = 1'b0;
        tick();

        // Two returns walk mie up from reset: (0,0) -> (0,1) -> (1,1).
        expect_redirect(32'h0, 32'h0, 32'h0, "ret0");
        do_mret();
        check("ret0_mie",  32'(bus.mstatus_mie),  0);
        check("ret0_mpie", 32'(bus.mstatus_mpie), 1);
        expect_redirect(32'h0, 32'h0, 32'h0, "ret0b");
        do_mret();
        check("ret0b_mie",  32'(bus.mstatus_mie),  1);
        check("ret0b_mpie", 32'(bus.mstatus_mpie), 1);

        // Exceptions 2 and 8 together: lowest wins, base target even in vectored mode.
        bus.mtvec = 32'h1001; bus.epc = 32'h80; bus.tval = 32'h55;
        bus.exc_src = 16'h0104; bus.pipe_clear = 1'b1;
        expect_redirect(32'h1000, 32'h2, 32'h80, "exc");
        tick();
        bus.exc_src = '0;
        check("exc_busy",        32'(bus.busy),      1);
        check("exc_no_early_pc", 32'(bus.insert_pc), 0);
        tick(2);
        bus.pipe_clear = 1'b0;
        check("exc_done",  32'(exp_q.size()),      0);
        check("exc_mie",   32'(bus.mstatus_mie),   0);
        check("exc_mpie",  32'(bus.mstatus_mpie),  1);
        check("exc_mtval", bus.mtval,              32'h55);
        expect_redirect(32'h80, 32'h2, 32'h80, "ret1");
        do_mret();
        check("ret1_mie", 32'(bus.mstatus_mie), 1);

        // Vectored interrupt: sources 3 and 11, highest wins, 0x1000 + 4*11.
        bus.int_mask = '1; bus.int_src = 16'h0808; bus.epc = 32'h300; bus.pipe_clear = 1'b1;
        expect_redirect(32'h102C, 32'h8000000B, 32'h300, "vint");
        tick();
        bus.int_src = '0;
        tick(3);
        bus.pipe_clear = 1'b0;
        check("vint_done",  32'(exp_q.size()),     0);
        check("vint_mtval", bus.mtval,             0);
        check("vint_mie",   32'(bus.mstatus_mie),  0);
        clear_pending();
        tick();
        check("vint_cleared", 32'(bus.pending), 0);
        expect_redirect(32'h300, 32'h8000000B, 32'h300, "ret2");
        do_mret();

        // Exception arriving in WAIT overrides the waiting interrupt.
        bus.int_src = 16'h0080; bus.epc = 32'h400;
        tick();
        bus.int_src = '0;
        tick();
        check("ovr_int_cause", bus.mcause, 32'h80000007);
        bus.exc_src = 16'h0020; bus.epc = 32'h500; bus.tval = 32'h77;
        expect_redirect(32'h1000, 32'h5, 32'h500, "ovr");
        tick();
        bus.exc_src = '0; bus.pipe_clear = 1'b1;
        check("ovr_mepc", bus.mepc, 32'h500);
        tick(2);
        bus.pipe_clear = 1'b0;
        check("ovr_done", 32'(exp_q.size()), 0);
        clear_pending();
        expect_redirect(32'h500, 32'h5, 32'h500, "ret3");
        do_mret();
        check("ret3_mie", 32'(bus.mstatus_mie), 1);

        // Waiting interrupt abandoned once its pending bit is cleared.
        bus.int_src = 16'h0010; bus.epc = 32'h700;
        tick();
        bus.int_src = '0;
        tick();
        bus.int_clear = 16'h0010;
        tick();
        bus.int_clear = '0;
        check("abn_busy_wait", 32'(bus.busy),    1);
        check("abn_pending",   32'(bus.pending), 0);
        tick();
        check("abn_idle",   32'(bus.busy), 0);
        check("abn_mcause", bus.mcause,    32'h80000004);
        bus.pipe_clear = 1'b1;
        tick(3);
        bus.pipe_clear = 1'b0;

        // Reset while waiting aborts without a redirect.
        bus.int_src = 16'h0002;
        tick();
        bus.int_src = '0;
        tick();
        check("rw_busy_wait", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_busy",    32'(bus.busy),         0);
        check("rw_pending", 32'(bus.pending),      0);
        check("rw_mcause",  bus.mcause,            0);
        check("rw_mepc",    bus.mepc,              0);
        check("rw_mie",     32'(bus.mstatus_mie),  0);
        check("rw_mpie",    32'(bus.mstatus_mpie), 0);
        bus.pipe_clear = 1'b1;
        tick(2);
        bus.pipe_clear = 1'b0;

        // Same-cycle set and clear of one source leaves it pending.
        bus.int_src = 16'h0004; bus.int_clear = 16'h0004;
        tick();
        bus.int_src = '0; bus.int_clear = '0;
        check("setclr_pending", 32'(bus.pending), 32'h4);
        bus.int_clear = 16'h0004;
        tick();
        bus.int_clear = '0;
        check("clr_pending", 32'(bus.pending), 0);

        // Trap and mret in the same IDLE cycle: trap wins, mret is dropped.
        bus.mtvec = 32'h2000; bus.epc = 32'h600; bus.tval = 32'h0;
        bus.exc_src = 16'h0001; bus.mret = 1'b1; bus.pipe_clear = 1'b1;
        expect_redirect(32'h2000, 32'h0, 32'h600, "trap_vs_mret");
        tick();
        bus.exc_src = '0; bus.mret = 1'b0;
        check("tvm_busy", 32'(bus.busy), 1);
        tick(2);
        bus.pipe_clear = 1'b0;
        check("tvm_idle", 32'(bus.busy),         0);
        check("tvm_mpie", 32'(bus.mstatus_mpie), 0);
        tick();
        check("tvm_no_ret", 32'(bus.busy), 0);

        tick(2);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
